// File: rtl/game_flow_ctrl_pkg.sv
// Shared game-flow types and default phase lengths (in frames).
package asteroids;

  typedef enum logic [2:0] {
    TITLE     = 3'd0,
    WAVE_WAIT = 3'd1,
    PLAY      = 3'd2,
    RESPAWN   = 3'd3,
    GAME_OVER = 3'd4
  } game_state_t;

  localparam int TITLE_FRAMES_DEF   = 255;
  localparam int WAVE_FRAMES_DEF    = 90;
  localparam int RESPAWN_FRAMES_DEF = 120;
  localparam int INVULN_FRAMES_DEF  = 60;

  localparam logic [3:0] LEVEL_MAX = 4'd15;

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Input controls and registered draw/flow outputs of the game flow controller.
interface game_flow_ctrl_if;
  import asteroids::*;

  logic        frame_tick;
  logic        skip;
  logic        die;
  logic        lives_zero;
  logic        wave_clear;

  game_state_t state;
  logic [7:0]  title_scale;
  logic        title_en;
  logic        ship_en;
  logic        ast_en;
  logic        gameover_en;
  logic        new_level;
  logic        respawn;
  logic        invuln;
  logic [3:0]  level;

  modport master (
    output frame_tick, skip, die, lives_zero, wave_clear,
    input  state, title_scale, title_en, ship_en, ast_en, gameover_en,
           new_level, respawn, invuln, level
  );

  modport slave (
    input  frame_tick, skip, die, lives_zero, wave_clear,
    output state, title_scale, title_en, ship_en, ast_en, gameover_en,
           new_level, respawn, invuln, level
  );

endinterface

// File: rtl/game_flow_ctrl_timer.sv
// 8-bit frame down-counter: load wins over tick, holds at zero.
module frame_timer (
  input  logic       clk,
  input  logic       resetN,
  input  logic       tick_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic       zero_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (tick_i && (cnt_q != 8'd0))
      cnt_d = cnt_q - 8'd1;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) cnt_q <= 8'd0;
    else         cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == 8'd0);

endmodule

// File: rtl/game_flow_ctrl.sv
// Asteroids game flow sequencer: title, wave delay, play, respawn, game over.
module game_flow_ctrl
  import asteroids::*;
#(
  parameter int TITLE_FRAMES   = TITLE_FRAMES_DEF,
  parameter int WAVE_FRAMES    = WAVE_FRAMES_DEF,
  parameter int RESPAWN_FRAMES = RESPAWN_FRAMES_DEF,
  parameter int INVULN_FRAMES  = INVULN_FRAMES_DEF
) (
  input  logic             clk,
  input  logic             resetN,
  game_flow_ctrl_if.slave  bus
);

  localparam logic [7:0] TITLE_LAST   = 8'(TITLE_FRAMES - 1);
  localparam logic [7:0] WAVE_LAST    = 8'(WAVE_FRAMES - 1);
  localparam logic [7:0] RESPAWN_LAST = 8'(RESPAWN_FRAMES - 1);
  localparam logic [7:0] INVULN_LOAD  = 8'(INVULN_FRAMES);

  game_state_t state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  scale_q, scale_d;
  logic [3:0]  level_q, level_d;
  logic        new_level_q, new_level_d;
  logic        respawn_q, respawn_d;
  logic        title_en_q, ship_en_q, ast_en_q, go_en_q;
  logic        inv_zero;
  logic        invuln;

  assign invuln = ~inv_zero;

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    new_level_d = 1'b0;
    respawn_d   = 1'b0;
    case (state_q)
      TITLE: begin
        if (bus.frame_tick && (bus.skip || (cnt_q == TITLE_LAST))) begin
          state_d = WAVE_WAIT;
          level_d = 4'd1;
        end
      end
      WAVE_WAIT: begin
        if (bus.frame_tick && (cnt_q == WAVE_LAST)) begin
          state_d     = PLAY;
          new_level_d = 1'b1;
        end
      end
      PLAY: begin
        // A collision outranks a cleared field; the wave is re-checked after respawn.
        if (bus.die && !invuln) begin
          state_d = bus.lives_zero ? GAME_OVER : RESPAWN;
        end else if (bus.wave_clear) begin
          state_d = WAVE_WAIT;
          if (level_q != LEVEL_MAX) level_d = level_q + 4'd1;
        end
      end
      RESPAWN: begin
        if (bus.frame_tick && (cnt_q == RESPAWN_LAST)) begin
          state_d   = PLAY;
          respawn_d = 1'b1;
        end
      end
      GAME_OVER: state_d = GAME_OVER;
      default:   state_d = TITLE;
    endcase

    if (state_d != state_q)
      cnt_d = 8'd0;
    else if (bus.frame_tick)
      cnt_d = cnt_q + 8'd1;
    else
      cnt_d = cnt_q;

    scale_d = (state_d == TITLE) ? cnt_d : 8'd0;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= TITLE;
      cnt_q       <= 8'd0;
      scale_q     <= 8'd0;
      level_q     <= 4'd0;
      new_level_q <= 1'b0;
      respawn_q   <= 1'b0;
      title_en_q  <= 1'b1;
      ship_en_q   <= 1'b0;
      ast_en_q    <= 1'b0;
      go_en_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      scale_q     <= scale_d;
      level_q     <= level_d;
      new_level_q <= new_level_d;
      respawn_q   <= respawn_d;
      title_en_q  <= (state_d == TITLE);
      ship_en_q   <= (state_d == PLAY);
      ast_en_q    <= (state_d == WAVE_WAIT) || (state_d == PLAY) || (state_d == RESPAWN);
      go_en_q     <= (state_d == GAME_OVER);
    end
  end

  frame_timer u_invuln (
    .clk        (clk),
    .resetN     (resetN),
    .tick_i     (bus.frame_tick),
    .load_i     (respawn_d),
    .load_val_i (INVULN_LOAD),
    .zero_o     (inv_zero)
  );

  assign bus.state       = state_q;
  assign bus.title_scale = scale_q;
  assign bus.title_en    = title_en_q;
  assign bus.ship_en     = ship_en_q;
  assign bus.ast_en      = ast_en_q;
  assign bus.gameover_en = go_en_q;
  assign bus.new_level   = new_level_q;
  assign bus.respawn     = respawn_q;
  assign bus.invuln      = invuln;
  assign bus.level       = level_q;

endmodule

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 Parameter TITLE_FRAMES, default 255, frame count of title zoom phase (legal 1..255).
REQ-002 Parameter WAVE_FRAMES, default 90, frame delay before each asteroid wave (legal 1..255).
REQ-003 Parameter RESPAWN_FRAMES, default 120, frame delay after ship loss (legal 1..255).
REQ-004 Parameter INVULN_FRAMES, default 60, frames of post-respawn invulnerability (legal 1..255).
REQ-005 clk  in  1  25 MHz pixel clock; sole clock.
REQ-006 resetN  in  1  asynchronous active-low reset.
REQ-007 frame_tick  in  1  one-cycle pulse per frame (vsync rising edge).
REQ-008 skip  in  1  level-sensitive fire button; ends title early.
REQ-009 die  in  1  ship/asteroid collision, level-sensitive.
REQ-010 lives_zero  in  1  lives counter reports no lives left.
REQ-011 wave_clear  in  1  no asteroid currently alive.
REQ-012 state  out  3  current game_state_t.
REQ-013 title_scale  out  8  title sprite zoom factor.
REQ-014 title_en, ship_en, ast_en, gameover_en  out  1 each  draw/enable masks.
REQ-015 new_level  out  1  one-cycle pulse: spawn a new large-asteroid wave.
REQ-016 respawn  out  1  one-cycle pulse: recentre ship.
REQ-017 invuln  out  1  ship collisions masked.
REQ-018 level  out  4  current wave number, saturates at 15.

Function
REQ-019 States SHALL be TITLE, WAVE_WAIT, PLAY, RESPAWN, GAME_OVER; all outputs registered.
REQ-020 A single 8-bit frame_cnt SHALL increment only on frame_tick and clear to 0 on every state change.
REQ-021 TITLE: title_scale = frame_cnt; exit to WAVE_WAIT on the frame_tick where frame_cnt == TITLE_FRAMES-1, or on the first frame_tick with skip=1; level set to 1 on exit.
REQ-022 WAVE_WAIT: on frame_tick with frame_cnt == WAVE_FRAMES-1, assert new_level for exactly that next cycle and enter PLAY.
REQ-023 PLAY: die with invuln=0 -> GAME_OVER if lives_zero else RESPAWN; otherwise wave_clear -> WAVE_WAIT with level+1 (saturating 15).
REQ-024 Simultaneous die and wave_clear in PLAY: die SHALL win; wave_clear re-evaluated after respawn.
REQ-025 RESPAWN: die ignored; on frame_tick with frame_cnt == RESPAWN_FRAMES-1, pulse respawn one cycle, load invuln counter with INVULN_FRAMES, enter PLAY.
REQ-026 invuln SHALL be 1 while invuln counter nonzero; counter decrements on frame_tick, stops at 0; die ignored while invuln=1.
REQ-027 GAME_OVER: terminal until reset; all inputs ignored.
REQ-028 Masks: title_en=1 only in TITLE; ship_en=1 only in PLAY; ast_en=1 in WAVE_WAIT, PLAY, RESPAWN; gameover_en=1 only in GAME_OVER.
REQ-029 Inputs outside frame_tick cycles SHALL only affect transitions in PLAY (die, wave_clear act on any cycle).

Reset
REQ-030 On resetN=0: state=TITLE, frame_cnt=0, title_scale=0, level=0, invuln counter=0, title_en=1, all other outputs 0.
REQ-031 Reset asserted mid-phase SHALL abort immediately; no pending pulse SHALL be emitted after release.

Structure
REQ-032 game_state_t enum and default frame constants SHALL live in package asteroids.
REQ-033 One sub-module frame_timer (8-bit load/decrement on tick, zero flag) SHALL implement the invuln counter.

Verification (TITLE=4, WAVE=3, RESPAWN=2, INVULN=2)
REQ-034 Reset, 4 ticks -> title_scale 0,1,2,3, then WAVE_WAIT, level=1; 3 ticks -> single new_level pulse, PLAY, ship_en=1.
REQ-035 skip=1 at first tick in TITLE -> WAVE_WAIT after that tick, title_en=0.
REQ-036 PLAY, die, lives_zero=0 -> RESPAWN; 2 ticks -> respawn pulse, invuln=1; die during next 2 ticks ignored; invuln drops after tick 2.
REQ-037 PLAY, die and wave_clear same cycle, lives_zero=0 -> RESPAWN, level unchanged.
REQ-038 15 consecutive wave_clear cycles -> level saturates at 15, new_level pulses each wave.
REQ-039 PLAY, die with lives_zero=1 -> GAME_OVER, gameover_en=1, ast_en=0; further skip/die ignored; resetN low -> TITLE.
